// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction-fetch front end. Owns the PC, drives the
//            instruction-memory address, and captures the same-cycle read data
//            into a small FIFO of {pc, instruction} pairs. Decode drains the
//            FIFO with valid/ready. A redirect flushes the FIFO and reloads
//            the PC.
// Options  : FETCH_QUEUE_PERF_EN adds saturating stall and flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DEPTH         = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
  input  logic [ADDRESS_WIDTH-1:0] imem_rdata_i,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  output logic [ADDRESS_WIDTH-1:0] instr_o,
  output logic [ADDRESS_WIDTH-1:0] pc_o,
`ifdef FETCH_QUEUE_PERF_EN
  output logic [31:0]              stall_cnt_o,
  output logic [31:0]              flush_cnt_o,
`endif
  output logic                     full_o
);

  localparam int                     PTR_W      = $clog2(DEPTH);
  localparam int                     CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0]       C_DEPTH    = CNT_W'(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] C_PC_STEP  = ADDRESS_WIDTH'(4);
  localparam logic [ADDRESS_WIDTH-1:0] C_ALIGN_MASK = ~ADDRESS_WIDTH'(3);

  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic [CNT_W-1:0]         r_count;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [ADDRESS_WIDTH-1:0] r_mem_pc    [DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_mem_instr [DEPTH];

  logic w_valid;
  logic w_full;
  logic w_push;
  logic w_pop;

  // Full is judged on the pre-pop count, so a full queue never pushes even
  // while it is being drained; fetch resumes the following cycle.
  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == C_DEPTH);
  assign w_push  = !redirect_i && (r_count < C_DEPTH);
  assign w_pop   = w_valid && instr_ready_i && !redirect_i;

  assign imem_addr_o   = r_pc;
  assign instr_valid_o = w_valid;
  assign full_o        = w_full;
  // Head entry is forced to zero while empty so stale storage never leaks out.
  assign instr_o       = w_valid ? r_mem_instr[r_rd_ptr] : '0;
  assign pc_o          = w_valid ? r_mem_pc[r_rd_ptr]    : '0;

  // Storage is write-only on push; it needs no reset because count gates reads.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_pc;
      r_mem_instr[r_wr_ptr] <= imem_rdata_i;
    end
  end

  // PC, pointers and occupancy; redirect overrides push and pop alike.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pc     <= RESET_PC;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (redirect_i) begin
      r_pc     <= redirect_pc_i & C_ALIGN_MASK;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + C_PC_STEP;
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

  // Saturating counters: stalls are full non-redirect cycles, flushes are
  // redirects that actually discarded queued entries.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_full && !redirect_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (redirect_i && w_valid && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Directed self-checking bench for fetch_queue. Memory word n
//            holds 32'h1000_0000 + n. Inputs change 1 time unit after the
//            rising edge; outputs are observed at that same point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        full_o;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  assign imem_rdata_i = 32'h1000_0000 + {2'b00, imem_addr_o[31:2]};

  fetch_queue #(
    .ADDRESS_WIDTH(32),
    .DEPTH(4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .imem_addr_o(imem_addr_o),
    .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .instr_o(instr_o),
    .pc_o(pc_o),
`ifdef FETCH_QUEUE_PERF_EN
    .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o),
`endif
    .full_o(full_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Hold reset across an edge, check reset outputs, release 1 unit after an edge.
  task automatic test_reset(input logic ready);
    rst_n_i = 1'b0;
    redirect_i = 1'b0;
    instr_ready_i = ready;
    step();
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", instr_valid_o); end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", full_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 00000000", imem_addr_o); end
    checks++; if ({instr_o, pc_o} !== 64'h0) begin errors++; $display("FAIL rst_head got %h/%h exp 0/0", instr_o, pc_o); end
    step();
    rst_n_i = 1'b1;
  endtask

  task automatic test_stream();
    test_reset(1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i, instr_valid_o); end
      checks++; if (pc_o !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", i, pc_o, 32'(4 * i)); end
      checks++; if (instr_o !== 32'h1000_0000 + 32'(i)) begin errors++; $display("FAIL stream_instr[%0d] got %h exp %h", i, instr_o, 32'h1000_0000 + 32'(i)); end
    end
  endtask

  task automatic test_full_stall();
    logic [31:0] exp_pc [5];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    test_reset(1'b0);
    for (int j = 1; j <= 8; j++) begin
      step();
      checks++; if (full_o !== (j >= 4)) begin errors++; $display("FAIL stall_full[%0d] got %b exp %b", j, full_o, (j >= 4)); end
    end
    checks++; if (imem_addr_o !== 32'h10) begin errors++; $display("FAIL stall_addr got %h exp 00000010", imem_addr_o); end
`ifdef FETCH_QUEUE_PERF_EN
    checks++; if (stall_cnt_o !== 32'd4) begin errors++; $display("FAIL stall_cnt got %0d exp 4", stall_cnt_o); end
`endif
    instr_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (pc_o !== exp_pc[k]) begin errors++; $display("FAIL drain_pc[%0d] got %h exp %h", k, pc_o, exp_pc[k]); end
      step();
    end
  endtask

  task automatic test_redirect();
    test_reset(1'b0);
    for (int j = 0; j < 5; j++) step();
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL redir_prefull got %b exp 1", full_o); end
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    step();
    redirect_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL redir_valid got %b exp 0", instr_valid_o); end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL redir_full got %b exp 0", full_o); end
    checks++; if (imem_addr_o !== 32'h100) begin errors++; $display("FAIL redir_addr got %h exp 00000100", imem_addr_o); end
    instr_ready_i = 1'b1;
    step();
    checks++; if (pc_o !== 32'h100) begin errors++; $display("FAIL redir_first_pc got %h exp 00000100", pc_o); end
    checks++; if (instr_o !== 32'h1000_0040) begin errors++; $display("FAIL redir_first_instr got %h exp 10000040", instr_o); end
    // Redirect coincides with ready on a valid head: the head is discarded.
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    step();
    redirect_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL redir_pop_valid got %b exp 0", instr_valid_o); end
    checks++; if (imem_addr_o !== 32'h200) begin errors++; $display("FAIL redir_pop_addr got %h exp 00000200", imem_addr_o); end
    step();
    checks++; if (pc_o !== 32'h200) begin errors++; $display("FAIL redir_pop_pc got %h exp 00000200", pc_o); end
    // Back-to-back redirects: the last one wins.
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0300;
    step();
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_valid0 got %b exp 0", instr_valid_o); end
    redirect_pc_i = 32'h0000_0402;
    step();
    redirect_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_valid1 got %b exp 0", instr_valid_o); end
    checks++; if (imem_addr_o !== 32'h400) begin errors++; $display("FAIL b2b_addr got %h exp 00000400", imem_addr_o); end
    step();
    checks++; if (pc_o !== 32'h400) begin errors++; $display("FAIL b2b_pc got %h exp 00000400", pc_o); end
`ifdef FETCH_QUEUE_PERF_EN
    checks++; if (stall_cnt_o !== 32'd1) begin errors++; $display("FAIL redir_stall_cnt got %0d exp 1", stall_cnt_o); end
    checks++; if (flush_cnt_o !== 32'd3) begin errors++; $display("FAIL redir_flush_cnt got %0d exp 3", flush_cnt_o); end
`endif
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_in [3];
    exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    exp_in = '{32'h4FFF_FFFE, 32'h4FFF_FFFF, 32'h1000_0000};
    instr_ready_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFF8;
    step();
    redirect_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (pc_o !== exp_pc[k]) begin errors++; $display("FAIL wrap_pc[%0d] got %h exp %h", k, pc_o, exp_pc[k]); end
      checks++; if (instr_o !== exp_in[k]) begin errors++; $display("FAIL wrap_instr[%0d] got %h exp %h", k, instr_o, exp_in[k]); end
    end
  endtask

  task automatic test_async_reset();
    checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b exp 1", instr_valid_o); end
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", instr_valid_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL arst_addr got %h exp 00000000", imem_addr_o); end
    checks++; if ({instr_o, pc_o} !== 64'h0) begin errors++; $display("FAIL arst_head got %h/%h exp 0/0", instr_o, pc_o); end
`ifdef FETCH_QUEUE_PERF_EN
    checks++; if ({stall_cnt_o, flush_cnt_o} !== 64'h0) begin errors++; $display("FAIL arst_cnt got %0d/%0d exp 0/0", stall_cnt_o, flush_cnt_o); end
`endif
    test_reset(1'b1);
    step();
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL arst_resume_pc got %h exp 00000000", pc_o); end
  endtask

  initial begin
    test_stream();
    test_full_stall();
    test_redirect();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
